// File: rtl/run_burst_arb.sv
// Purpose: round-robin scheduler granting one counted run engine to one of
//          NREQ requesters, sequencing each burst IDLE -> RUN -> LAST -> IDLE.
// Latency: every output is registered; a grant appears one cycle after the deciding edge.
// Backpressure: none; a granted burst runs to completion, and en only gates new grants.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_n_i     synchronous active-low reset
//   en_i        arbitration enable; blocks new grants only
//   req_i       level request vector, one bit per requester
//   req_len_i   burst length per requester, requester i at [i*CNT_W +: CNT_W]
//   abort_i     cuts the current RUN phase short
//   grant_o     one-hot grant, held from grant through LAST
//   grant_id_o  index of the granted requester, valid while busy_o
//   g_o         engine gate, high through RUN and LAST
//   last_o      one-cycle pulse while in LAST
//   f_o         toggles once per completed burst
//   busy_o      high whenever the FSM is not idle
module run_burst_arb #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*CNT_W-1:0] req_len_i,
  input  logic                  abort_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [2:0]            grant_id_o,
  output logic                  g_o,
  output logic                  last_o,
  output logic                  f_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   lim_q, lim_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               g_q, g_d;
  logic               last_q, last_d;
  logic               f_q, f_d;
  logic               busy_q, busy_d;

  // Arbitration results
  logic [7:0]         req_ext;
  logic               found;
  logic [2:0]         win;
  logic [CNT_W-1:0]   win_len;
  logic [CNT_W:0]     cnt_inc;

  // Round-robin search starting one past the last winner. The request
  // vector is widened to 8 bits so a 3-bit index is always in range.
  always_comb begin : pick
    req_ext              = '0;
    req_ext[NREQ-1:0]    = req_i;
    found                = 1'b0;
    win                  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_ext[3'((int'(ptr_q) + k) % NREQ)]) begin
        found = 1'b1;
        win   = 3'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Length of the winning requester, via a constant-index mux.
  always_comb begin : pick_len
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == win) begin
        win_len = req_len_i[i*CNT_W +: CNT_W];
      end
    end
  end

  // One extra bit so cnt+1 is compared against lim without wrapping.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin : next_state
    state_d    = state_q;
    cnt_d      = cnt_q;
    lim_d      = lim_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;

    case (state_q)
      S_IDLE: begin
        grant_d    = '0;
        grant_id_d = '0;
        cnt_d      = '0;
        if (en_i && found) begin
          state_d    = S_RUN;
          grant_id_d = win;
          ptr_d      = win;
          // A zero length still gets one RUN cycle.
          lim_d      = (win_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : win_len;
          for (int i = 0; i < NREQ; i++) begin
            grant_d[i] = (3'(i) == win);
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_inc[CNT_W-1:0];
        if ((cnt_inc == {1'b0, lim_q}) || abort_i) begin
          state_d = S_LAST;
        end
      end

      S_LAST: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end

      default: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase

    // Outputs follow the state being entered so they are registered
    // and aligned with the state they describe.
    g_d    = (state_d != S_IDLE);
    busy_d = (state_d != S_IDLE);
    last_d = (state_d == S_LAST);
    f_d    = f_q ^ ((state_q == S_RUN) && (state_d == S_LAST));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lim_q      <= '0;
      ptr_q      <= 3'(NREQ - 1);
      grant_q    <= '0;
      grant_id_q <= '0;
      g_q        <= 1'b0;
      last_q     <= 1'b0;
      f_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lim_q      <= lim_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      g_q        <= g_d;
      last_q     <= last_d;
      f_q        <= f_d;
      busy_q     <= busy_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign g_o        = g_q;
  assign last_o     = last_q;
  assign f_o        = f_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_run_burst_arb.sv
// Bench for run_burst_arb: directed bursts push expected records into a
// queue; a negedge monitor reconstructs each gate window and compares it.
module tb_run_burst_arb;
  localparam int NREQ  = 4;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_len;
  logic                  abort;
  logic [NREQ-1:0]       grant;
  logic [2:0]            grant_id;
  logic                  g;
  logic                  last;
  logic                  f;
  logic                  busy;

  always #5 clk = ~clk;

  run_burst_arb #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .req_i      (req),
    .req_len_i  (req_len),
    .abort_i    (abort),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .g_o        (g),
    .last_o     (last),
    .f_o        (f),
    .busy_o     (busy)
  );

  typedef struct {
    int   id;
    int   glen;
    int   nlast;
    logic f;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic exp_f      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_burst(input int id, input int glen);
    exp_t e;
    exp_f   = ~exp_f;
    e.id    = id;
    e.glen  = glen;
    e.nlast = 1;
    e.f     = exp_f;
    exp_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"},    grant,    0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_g"},        g,        0);
    check({tag, "_last"},     last,     0);
    check({tag, "_f"},        f,        0);
    check({tag, "_busy"},     busy,     0);
  endtask

  // Monitor state
  logic            g_p   = 1'b0;
  logic            l_p   = 1'b0;
  logic            f_p   = 1'b0;
  logic            rst_p = 1'b0;
  int              glen  = 0;
  int              nlast = 0;
  logic [NREQ-1:0] cg    = '0;
  logic [2:0]      cid   = '0;

  initial begin : monitor
    exp_t            e;
    logic [NREQ-1:0] oh;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("onehot0_grant", {31'd0, $onehot0(grant)}, 1);
      check("g_eq_busy", {31'd0, g}, {31'd0, busy});
      check("last_implies_g", {31'd0, (!last || g)}, 1);
      if (rst_p && (f !== f_p)) begin
        check("f_only_on_last_rise", {31'd0, (last && !l_p)}, 1);
      end

      if (g && !g_p) begin
        glen  = 1;
        nlast = int'(last);
        cg    = grant;
        cid   = grant_id;
      end else if (g) begin
        glen++;
        nlast += int'(last);
        check("grant_held", grant, cg);
      end else if (g_p) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_burst: got id %0d len %0d expected no burst", cid, glen);
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          check("burst_id",    cid,   e.id);
          check("burst_grant", cg,    oh);
          check("burst_glen",  glen,  e.glen);
          check("burst_nlast", nlast, e.nlast);
          check("burst_f",     f,     e.f);
        end
      end

      g_p   = g;
      l_p   = last;
      f_p   = f;
      rst_p = rst_n;
    end
  end

  initial begin : stimulus
    exp_t r;
    rst_n   = 1'b0;
    en      = 1'b0;
    req     = '0;
    req_len = '0;
    abort   = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // Rotation: all requesting, length 2 -> 0,1,2,3,0, grants every 4 cycles
    req_len = {4'd2, 4'd2, 4'd2, 4'd2};
    req     = 4'b1111;
    expect_burst(0, 3);
    expect_burst(1, 3);
    expect_burst(2, 3);
    expect_burst(3, 3);
    expect_burst(0, 3);
    repeat (17) tick();
    req = '0;
    repeat (6) tick();

    // Single burst, length 3
    req_len[3:0] = 4'd3;
    req = 4'b0001;
    expect_burst(0, 4);
    tick();
    req = '0;
    repeat (8) tick();

    // Zero length acts as 1
    req_len[7:4] = 4'd0;
    req = 4'b0010;
    expect_burst(1, 2);
    tick();
    req = '0;
    repeat (5) tick();

    // Maximum length, no counter wrap
    req_len[11:8] = 4'd15;
    req = 4'b0100;
    expect_burst(2, 16);
    tick();
    req = '0;
    repeat (20) tick();

    // Abort in the 3rd RUN cycle of a length-10 burst
    req_len[15:12] = 4'd10;
    req = 4'b1000;
    expect_burst(3, 4);
    tick();
    req = '0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (6) tick();

    // Abort while idle has no effect
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    tick();

    // Abort coinciding with terminal count: normal LAST, single toggle
    req_len[3:0] = 4'd2;
    req = 4'b0001;
    expect_burst(0, 3);
    tick();
    req = '0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();

    // Enable gating
    en = 1'b0;
    req_len[11:8] = 4'd4;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_gate_grant", grant, 0);
      check("en_gate_g", {31'd0, g}, 0);
    end
    en = 1'b1;
    expect_burst(2, 5);
    tick();
    en  = 1'b0;
    req = '0;
    repeat (8) tick();
    en = 1'b1;

    // Reset in RUN cycle 2: window of 2, no LAST, f forced to 0
    req_len[3:0] = 4'd6;
    req = 4'b0001;
    r.id = 0; r.glen = 2; r.nlast = 0; r.f = 1'b0;
    exp_q.push_back(r);
    exp_f = 1'b0;
    tick();
    req = '0;
    tick();
    rst_n = 1'b0;
    tick();
    check_idle_outputs("midreset");

    // After release the pointer restarts: requester 0 beats requester 2
    rst_n = 1'b1;
    req_len[3:0] = 4'd1;
    req = 4'b0101;
    expect_burst(0, 2);
    tick();
    req = '0;
    repeat (6) tick();

    check("pending_bursts", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
